// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared vending types and timing defaults
//
// Purpose: dispenser state encoding, default change-dispenser timing and
// the change-amount width shared with the vending controller.
// Ports: none (package).
package vend_pkg;

  // Width of a change amount; the vending controller's change output uses it too.
  localparam int AMNT_W      = 3;

  // Default dispenser timing, in clk cycles.
  localparam int PULSE_CYC   = 4;
  localparam int GAP_CYC     = 2;
  localparam int TIMEOUT_CYC = 16;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PULSE      = 3'd1,
    ST_WAIT_SENSE = 3'd2,
    ST_GAP        = 3'd3,
    ST_DONE       = 3'd4,
    ST_FAULT      = 3'd5
  } disp_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/change_dispenser_sense_sync.sv
// rtl/change_dispenser_sense_sync.sv - hopper sensor synchronizer and rise detector
//
// Purpose: brings the asynchronous hopper exit sensor into the clk domain
// and produces a registered one-cycle event on each rising edge.
// Ports:
//   clk         in  clock
//   rst_n       in  asynchronous active-low reset
//   sense_async in  raw hopper exit sensor
//   sense_evt   out one-cycle pulse per synchronized rising edge
module sense_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sense_async,
  output logic sense_evt
);

  logic sync_1;
  logic sync_2;
  logic sync_2_prev;

  // sense_evt is registered, so a sensor rise shows up three edges later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1      <= 1'b0;
      sync_2      <= 1'b0;
      sync_2_prev <= 1'b0;
      sense_evt   <= 1'b0;
    end else begin
      sync_1      <= sense_async;
      sync_2      <= sync_1;
      sync_2_prev <= sync_2;
      sense_evt   <= sync_2 & ~sync_2_prev;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - coin-by-coin change payout with jam detection
//
// Purpose: accepts a change amount over valid/ready, pulses the coin hopper
// once per coin, waits for the exit sensor to confirm each coin and reports
// done, or a latched jam fault if the sensor stays silent.
// Ports:
//   clk         in  clock
//   rst_n       in  asynchronous active-low reset
//   req_valid   in  change request present
//   req_amnt    in  coins to dispense
//   req_ready   out request accepted when high (IDLE only)
//   coin_pulse  out hopper eject drive (registered)
//   coin_sense  in  hopper exit sensor (asynchronous)
//   remaining   out coins still owed
//   done        out one-cycle completion pulse
//   fault       out sensor timeout level
//   fault_clr   in  clears the fault (honoured in FAULT only)
module change_dispenser
  import vend_pkg::*;
#(
  parameter int AMNT_W      = vend_pkg::AMNT_W,
  parameter int PULSE_CYC   = vend_pkg::PULSE_CYC,
  parameter int GAP_CYC     = vend_pkg::GAP_CYC,
  parameter int TIMEOUT_CYC = vend_pkg::TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [AMNT_W-1:0] req_amnt,
  output logic              req_ready,
  output logic              coin_pulse,
  input  logic              coin_sense,
  output logic [AMNT_W-1:0] remaining,
  output logic              done,
  output logic              fault,
  input  logic              fault_clr
);

  localparam int CNT_MAX = max3(PULSE_CYC, GAP_CYC, TIMEOUT_CYC);
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  disp_state_e      state;
  disp_state_e      next_state;
  logic [CNT_W-1:0] cnt;
  logic             sense_evt;
  logic             ready_en;
  logic             accept;
  logic             timed_state;

  sense_sync u_sense_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .sense_async (coin_sense),
    .sense_evt   (sense_evt)
  );

  // ready_en keeps req_ready low while reset is held even though the
  // state register already sits in IDLE.
  assign req_ready   = ready_en && (state == ST_IDLE);
  assign accept      = req_valid && req_ready;
  assign done        = (state == ST_DONE);
  assign fault       = (state == ST_FAULT);
  assign timed_state = (state == ST_PULSE) || (state == ST_GAP) ||
                       (state == ST_WAIT_SENSE);

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          next_state = (req_amnt == '0) ? ST_DONE : ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (cnt == CNT_W'(PULSE_CYC - 1)) next_state = ST_WAIT_SENSE;
      end
      ST_WAIT_SENSE: begin
        // A sense event on the last timeout cycle still counts the coin.
        if (sense_evt) begin
          next_state = (remaining == AMNT_W'(1)) ? ST_DONE : ST_GAP;
        end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          next_state = ST_FAULT;
        end
      end
      ST_GAP: begin
        if (cnt == CNT_W'(GAP_CYC - 1)) next_state = ST_PULSE;
      end
      ST_DONE:  next_state = ST_IDLE;
      ST_FAULT: begin
        if (fault_clr) next_state = ST_IDLE;
      end
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      remaining  <= '0;
      coin_pulse <= 1'b0;
      ready_en   <= 1'b0;
    end else begin
      state      <= next_state;
      ready_en   <= 1'b1;
      coin_pulse <= (next_state == ST_PULSE);

      // Shared cycle counter restarts on every state change.
      if (next_state != state) begin
        cnt <= '0;
      end else if (timed_state) begin
        cnt <= cnt + CNT_W'(1);
      end

      if (state == ST_IDLE && accept) begin
        remaining <= req_amnt;
      end else if (state == ST_WAIT_SENSE && sense_evt) begin
        remaining <= remaining - AMNT_W'(1);
      end else if (state == ST_FAULT && fault_clr) begin
        remaining <= '0;
      end
    end
  end

endmodule
